ahb_data_sram: RTL and testbench
================================

Name: ahb_data_sram

Overview:
- AHB-style slave data memory: the responder end of the CPU's data bus (DATA_HADDR/HTRANS/HWDATA/HRDATA/HWRITE/HSIZE/HBUST/HRESP/HREADY) driven by MAU.
- Decodes address/data phases and serves byte, halfword and word loads and stores from an internal word array.
- Inserts a programmable number of wait states and returns a two-cycle ERROR response on illegal accesses.
- Used as the SoC data RAM and as the bench target for MAU.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to MEM_WORDS*4).
- WAIT_STATES, 0, extra HREADY-low cycles per OKAY data phase (0..15).

Ports:
- clk  in  1  single clock (HCLK).
- reset  in  1  asynchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address (address phase).
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBUST  in  3  burst type; accepted, ignored (each beat decoded independently).
- HWDATA  in  32  write data (data phase).
- HRDATA  out  32  read data (data phase).
- HRESP  out  2  00 OKAY, 01 ERROR.
- HREADY  out  1  data phase complete.

Behaviour:
- Reset (async, immediate): state IDLE, HREADY=1, HRESP=00, HRDATA=0, wait counter=0, pending data-phase info cleared. Any in-flight write is discarded. Array contents are not cleared.
- Address phase is accepted on a rising edge with HREADY=1 && HSEL && HTRANS[1]. On acceptance, HADDR, HWRITE and HSIZE are registered as data-phase info.
- IDLE, BUSY, or HSEL=0 with HREADY=1: next cycle is a zero-wait OKAY with no access.
- Error check at acceptance; any of the following triggers ERROR:
  - HSIZE > 010.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0]!=00.
  - HADDR outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4).
- States:
  - IDLE: HREADY=1, HRESP=00. Accepted legal transfer -> WAIT if WAIT_STATES>0, else DATA. Accepted illegal transfer -> ERR1.
  - WAIT: HREADY=0, HRESP=00. Counter loaded with WAIT_STATES-1, decrements each cycle; at 0 -> DATA.
  - DATA: HREADY=1, HRESP=00. Completes the transfer. The same edge may accept the next address phase (back-to-back, pipelined): -> WAIT/DATA/ERR1 on acceptance, else -> IDLE.
  - ERR1: HREADY=0, HRESP=01 -> ERR2.
  - ERR2: HREADY=1, HRESP=01. May accept the next address phase, same rules as DATA.
- Read:
  - HRDATA = full word mem[(dp_addr-BASE_ADDR)>>2] during WAIT and DATA. Bytes sit on their natural lanes (byte at addr[1:0]=n on bits 8n+7:8n); MAU extracts.
  - HRDATA=0 in all other states and for writes.
  - Latency with WAIT_STATES=W: data valid W+1 cycles after the address-phase edge.
- Write:
  - HWDATA is sampled and committed at the rising edge ending the DATA cycle (HREADY=1). Only lanes selected by dp_size/dp_addr[1:0] are written.
  - Lane enables: byte -> 1<<addr[1:0]; halfword -> 0011 or 1100; word -> 1111.
  - Nothing is written on ERROR, IDLE or BUSY.
- Read-after-write to the same address in consecutive transfers returns the new data: the write commits before the following data phase reads.
- HRESP=01 appears only in ERR1/ERR2.
- HBUST is not checked; SEQ beats behave as NONSEQ.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HRESP codes OKAY/ERROR.
  - HSIZE codes BYTE/HALF/WORD.
  - State encoding IDLE/WAIT/DATA/ERR1/ERR2.
  - Lane-enable function (size, addr[1:0]) -> 4-bit strobe.
- One sub-module, sram_bytewise: MEM_WORDS x 32 array with asynchronous read, synchronous write, and a 4-bit byte-lane write enable.

Test Plan:
- Word write then read, W=0: NONSEQ write 0x10 size 010, HWDATA 0xDEADBEEF; next NONSEQ read 0x10 -> HREADY stays 1, HRDATA=0xDEADBEEF in the read data phase, HRESP=00.
- Sub-word stores: word 0x20=0x11223344; byte write 0x21 data 0x0000AA00; halfword write 0x22 data 0xBBCC0000; read 0x20 -> 0xBBCCAA44.
- Wait states, WAIT_STATES=2: read 0x10 -> HREADY low exactly 2 cycles, then high with 0xDEADBEEF; back-to-back write accepted on that edge.
- Errors: word read at 0x13, halfword at 0x11, HSIZE=011, and address BASE_ADDR+MEM_WORDS*4 -> each gives HREADY 0 then 1 with HRESP=01 both cycles. A preceding word 0x10 is unchanged afterward.
- IDLE/BUSY/HSEL=0 with HWRITE=1, HWDATA=0xFFFFFFFF at 0x10 -> zero-wait OKAY, memory unchanged, HRDATA=0.
- Reset mid-WAIT (W=3, write pending): assert reset in the 2nd wait cycle -> HREADY=1, HRESP=00, HRDATA=0 immediately. After release the target word is unchanged and a new read is serviced normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, responder state encoding and the byte-lane strobe helper
// for the data-bus SRAM slave.
package ahb_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      SIZE_BYTE = 3'b000,
      SIZE_HALF = 3'b001,
      SIZE_WORD = 3'b010
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] strobe;
      strobe = 4'b0000;
      case (size)
         SIZE_BYTE: strobe = 4'b0001 << lane;
         SIZE_HALF: strobe = lane[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: strobe = 4'b1111;
         default:   strobe = 4'b0000;
      endcase
      return strobe;
   endfunction

endpackage

// File: rtl/sram_bytewise.sv
// Word-organised memory with asynchronous read and a per-byte-lane synchronous
// write enable.
module sram_bytewise #(
   parameter int MEM_WORDS = 1024
) (
   input  logic                         clk,
   input  logic [3:0]                   lane_we,
   input  logic [$clog2(MEM_WORDS)-1:0] addr,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata
);

   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (lane_we[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_data_sram.sv
// AHB data-bus responder: decodes address/data phases, serves sub-word loads and
// stores from a word array, inserts wait states and answers illegal accesses with ERROR.
module ahb_data_sram
   import ahb_pkg::*;
#(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBUST,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP,
   output logic        HREADY
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e          state_reg, state_next;
   logic [3:0]      wait_cnt_reg, wait_cnt_next;
   logic [31:0]     dp_addr_reg;
   logic            dp_write_reg;
   logic [2:0]      dp_size_reg;
   logic            accept;
   logic            illegal;
   logic [31:0]     offset;
   logic [31:0]     mem_rdata;
   logic [3:0]      lane_we;
   logic [AW-1:0]   word_idx;
   logic            unused_bits;

   // Unsigned wrap makes addresses below BASE_ADDR land far above MEM_BYTES.
   assign offset = HADDR - BASE_ADDR;

   always_comb begin
      illegal = 1'b0;
      if (HSIZE > SIZE_WORD)                           illegal = 1'b1;
      if (HSIZE == SIZE_HALF && HADDR[0])              illegal = 1'b1;
      if (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00)   illegal = 1'b1;
      if (offset >= MEM_BYTES)                         illegal = 1'b1;
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      HREADY        = 1'b1;
      HRESP         = RESP_OKAY;
      HRDATA        = '0;
      accept        = 1'b0;
      case (state_reg)
         ST_WAIT: begin
            HREADY = 1'b0;
            if (!dp_write_reg) HRDATA = mem_rdata;
            if (wait_cnt_reg == 4'd0) state_next = ST_DATA;
            else wait_cnt_next = wait_cnt_reg - 4'd1;
         end
         ST_DATA: begin
            if (!dp_write_reg) HRDATA = mem_rdata;
         end
         ST_ERR1: begin
            HREADY     = 1'b0;
            HRESP      = RESP_ERROR;
            state_next = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP = RESP_ERROR;
         end
         default: ;
      endcase
      // Any ready cycle ends the current data phase and may start the next one.
      accept = HREADY && HSEL && HTRANS[1];
      if (HREADY) begin
         state_next = ST_IDLE;
         if (accept) begin
            if (illegal) begin
               state_next = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_next    = ST_WAIT;
               wait_cnt_next = WAIT_LOAD;
            end else begin
               state_next = ST_DATA;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 4'd0;
         dp_addr_reg  <= '0;
         dp_write_reg <= 1'b0;
         dp_size_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (accept) begin
            dp_addr_reg  <= HADDR;
            dp_write_reg <= HWRITE;
            dp_size_reg  <= HSIZE;
         end
      end
   end

   // BASE_ADDR is aligned to the array size, so the low address bits are the word offset.
   assign word_idx = dp_addr_reg[AW+1:2];
   assign lane_we  = (state_reg == ST_DATA && dp_write_reg) ?
                     lane_strobe(dp_size_reg, dp_addr_reg[1:0]) : 4'b0000;

   sram_bytewise #(
      .MEM_WORDS (MEM_WORDS)
   ) u_sram (
      .clk     (clk),
      .lane_we (lane_we),
      .addr    (word_idx),
      .wdata   (HWDATA),
      .rdata   (mem_rdata)
   );

   assign unused_bits = ^{HBUST, dp_addr_reg[31:AW+2]};

endmodule

// File: tb/tb_ahb_data_sram.sv
// Randomised bench for ahb_data_sram: three instances (0, 2 and 3 wait states) checked
// every cycle against a transfer-level model of the expected bus response.
module tb_ahb_data_sram;

   localparam int          NI        = 3;
   localparam int          MW        = 64;
   localparam logic [31:0] MEM_BYTES = 32'(MW * 4);

   logic        clk = 1'b0;
   logic        rst    [NI];
   logic        hsel   [NI];
   logic [31:0] haddr  [NI];
   logic [1:0]  htrans [NI];
   logic        hwrite [NI];
   logic [2:0]  hsize  [NI];
   logic [2:0]  hburst [NI];
   logic [31:0] hwdata [NI];
   logic [31:0] hrdata [NI];
   logic [1:0]  hresp  [NI];
   logic        hready [NI];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Expected bus response per cycle slot, idle unless a transfer scheduled otherwise.
   logic        e_rdy  [NI][16];
   logic [1:0]  e_resp [NI][16];
   logic [31:0] e_data [NI][16];

   logic [31:0] mdl       [NI][MW];
   bit          pend_v    [NI];
   int          pend_idx  [NI];
   logic [3:0]  pend_strb [NI];
   logic [31:0] pend_data [NI];

   logic [31:0] last_rdata [NI];
   logic [1:0]  last_resp  [NI];
   int          last_waits [NI];

   always #5 clk = ~clk;

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 0) ? 32'h0000_0000 : ((k == 1) ? 32'h0000_1000 : 32'h2000_0000);
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      ahb_data_sram #(
         .MEM_WORDS   (MW),
         .BASE_ADDR   ((gi == 0) ? 32'h0000_0000 : ((gi == 1) ? 32'h0000_1000 : 32'h2000_0000)),
         .WAIT_STATES ((gi == 0) ? 0 : ((gi == 1) ? 2 : 3))
      ) dut (
         .clk    (clk),
         .reset  (rst[gi]),
         .HSEL   (hsel[gi]),
         .HADDR  (haddr[gi]),
         .HTRANS (htrans[gi]),
         .HWRITE (hwrite[gi]),
         .HSIZE  (hsize[gi]),
         .HBUST  (hburst[gi]),
         .HWDATA (hwdata[gi]),
         .HRDATA (hrdata[gi]),
         .HRESP  (hresp[gi]),
         .HREADY (hready[gi])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   task automatic put(input int k, input int c, input logic r, input logic [1:0] p, input logic [31:0] d);
      e_rdy[k][c % 16]  = r;
      e_resp[k][c % 16] = p;
      e_data[k][c % 16] = d;
   endtask

   task automatic model_reset(input int k);
      pend_v[k] = 1'b0;
      for (int s = 0; s < 16; s++) put(k, s, 1'b1, 2'b00, 32'h0);
   endtask

   function automatic bit legal(input int k, input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] off;
      off = addr - base_of(k);
      if (size > 3'd2) return 1'b0;
      if (size == 3'd1 && addr[0]) return 1'b0;
      if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b0;
      return off < MEM_BYTES;
   endfunction

   function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
      if (size == 3'd0) return 4'b0001 << a;
      if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   // Called right after the edge that ends the previous data phase and opens this one.
   task automatic schedule(input int k, input bit sel, input logic [1:0] tr, input logic [31:0] addr,
                           input bit wr, input logic [2:0] size, input logic [31:0] wd);
      int          c;
      int          idx;
      logic [31:0] rd;
      logic [31:0] off;
      c = cyc;
      if (pend_v[k]) begin
         for (int b = 0; b < 4; b++)
            if (pend_strb[k][b]) mdl[k][pend_idx[k]][8*b +: 8] = pend_data[k][8*b +: 8];
         pend_v[k] = 1'b0;
      end
      if (!sel || !tr[1]) begin
         put(k, c, 1'b1, 2'b00, 32'h0);
      end else if (!legal(k, addr, size)) begin
         put(k, c, 1'b0, 2'b01, 32'h0);
         put(k, c + 1, 1'b1, 2'b01, 32'h0);
      end else begin
         off = addr - base_of(k);
         idx = int'(off >> 2);
         rd  = wr ? 32'h0 : mdl[k][idx];
         for (int i = 0; i < ws_of(k); i++) put(k, c + i, 1'b0, 2'b00, rd);
         put(k, c + ws_of(k), 1'b1, 2'b00, rd);
         if (wr) begin
            pend_v[k]    = 1'b1;
            pend_idx[k]  = idx;
            pend_strb[k] = strb_of(size, addr[1:0]);
            pend_data[k] = wd;
         end
      end
   endtask

   // Entered and left at a falling edge; the address phase is held until a ready edge takes it.
   task automatic xfer(input int k, input bit sel, input logic [1:0] tr, input logic [31:0] addr,
                       input bit wr, input logic [2:0] size, input logic [31:0] wd);
      int waits;
      bit rdy;
      waits     = 0;
      hsel[k]   = sel;
      htrans[k] = tr;
      haddr[k]  = addr;
      hwrite[k] = wr;
      hsize[k]  = size;
      hburst[k] = 3'($urandom);
      forever begin
         rdy = hready[k];
         if (rdy) begin
            last_rdata[k] = hrdata[k];
            last_resp[k]  = hresp[k];
         end
         @(posedge clk);
         if (rdy) break;
         waits++;
         if (waits > 32) begin
            checks++;
            errors++;
            $display("FAIL bus%0d ready_timeout actual waits %0d required at most %0d", k, waits, ws_of(k));
            break;
         end
         @(negedge clk);
      end
      last_waits[k] = waits;
      schedule(k, sel, tr, addr, wr, size, wd);
      #1 hwdata[k] = wd;
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      xfer(k, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic directed0();
      logic [31:0] ea [4];
      logic [2:0]  es [4];
      bit          ew [4];
      ea = '{32'h13, 32'h11, 32'h10, MEM_BYTES};
      es = '{3'd2, 3'd1, 3'd3, 3'd2};
      ew = '{1'b0, 1'b1, 1'b1, 1'b1};
      xfer(0, 1, 2'b10, 32'h10, 1, 3'd2, 32'hDEADBEEF);
      xfer(0, 1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
      idle(0);
      check("bus0 raw_data", last_rdata[0], 32'hDEADBEEF);
      check("bus0 raw_resp", 32'(last_resp[0]), 32'h0);
      check("bus0 raw_waits", 32'(last_waits[0]), 32'd0);
      check("bus0 model_word10", mdl[0][4], 32'hDEADBEEF);
      xfer(0, 1, 2'b10, 32'h20, 1, 3'd2, 32'h11223344);
      xfer(0, 1, 2'b11, 32'h21, 1, 3'd0, 32'h0000AA00);
      xfer(0, 1, 2'b11, 32'h22, 1, 3'd1, 32'hBBCC0000);
      xfer(0, 1, 2'b10, 32'h20, 0, 3'd2, 32'h0);
      idle(0);
      check("bus0 subword_data", last_rdata[0], 32'hBBCCAA44);
      check("bus0 model_word20", mdl[0][8], 32'hBBCCAA44);
      for (int i = 0; i < 4; i++) begin
         xfer(0, 1, 2'b10, ea[i], ew[i], es[i], 32'hFFFFFFFF);
         idle(0);
         check($sformatf("bus0 err%0d_resp", i), 32'(last_resp[0]), 32'h1);
         check($sformatf("bus0 err%0d_waits", i), 32'(last_waits[0]), 32'd1);
      end
      xfer(0, 1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
      idle(0);
      check("bus0 after_err_data", last_rdata[0], 32'hDEADBEEF);
      xfer(0, 1, 2'b00, 32'h10, 1, 3'd2, 32'hFFFFFFFF);
      xfer(0, 1, 2'b01, 32'h10, 1, 3'd2, 32'hFFFFFFFF);
      xfer(0, 0, 2'b10, 32'h10, 1, 3'd2, 32'hFFFFFFFF);
      xfer(0, 1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
      check("bus0 noxfer_waits", 32'(last_waits[0]), 32'd0);
      idle(0);
      check("bus0 noxfer_data", last_rdata[0], 32'hDEADBEEF);
   endtask

   task automatic directed1();
      xfer(1, 1, 2'b10, 32'h1010, 1, 3'd2, 32'hDEADBEEF);
      xfer(1, 1, 2'b10, 32'h1010, 0, 3'd2, 32'h0);
      xfer(1, 1, 2'b10, 32'h1014, 1, 3'd2, 32'h0BADF00D);
      check("bus1 wait_count", 32'(last_waits[1]), 32'd2);
      check("bus1 wait_data", last_rdata[1], 32'hDEADBEEF);
      xfer(1, 1, 2'b10, 32'h1014, 0, 3'd2, 32'h0);
      idle(1);
      check("bus1 b2b_data", last_rdata[1], 32'h0BADF00D);
   endtask

   task automatic directed2();
      logic [31:0] old;
      old = mdl[2][12];
      xfer(2, 1, 2'b10, 32'h2000_0030, 1, 3'd2, 32'hCAFEF00D);
      hsel[2]   = 1'b0;
      htrans[2] = 2'b00;
      @(posedge clk);
      #1 rst[2] = 1'b1;
      model_reset(2);
      #1;
      check("bus2 rst_ready", 32'(hready[2]), 32'h1);
      check("bus2 rst_resp", 32'(hresp[2]), 32'h0);
      check("bus2 rst_data", hrdata[2], 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1 rst[2] = 1'b0;
      @(negedge clk);
      xfer(2, 1, 2'b10, 32'h2000_0030, 0, 3'd2, 32'h0);
      idle(2);
      check("bus2 post_rst_data", last_rdata[2], old);
      check("bus2 post_rst_waits", 32'(last_waits[2]), 32'd3);
   endtask

   task automatic run(input int k);
      logic [31:0] base;
      logic [31:0] addr;
      logic [31:0] low;
      logic [2:0]  size;
      int          r;
      base = base_of(k);
      for (int i = 0; i < MW; i++) xfer(k, 1, 2'b10, base + 32'(4 * i), 1, 3'd2, $urandom);
      idle(k);
      if (k == 0) directed0();
      else if (k == 1) directed1();
      else directed2();
      for (int n = 0; n < 250; n++) begin
         r    = int'($urandom % 16);
         size = (r < 14) ? 3'(r % 3) : 3'(3 + $urandom % 5);
         if ($urandom % 4 == 0 || size == 3'd0) low = 32'($urandom % 4);
         else if (size == 3'd1) low = 32'(2 * ($urandom % 2));
         else low = 32'h0;
         r = int'($urandom % 20);
         if (r == 0) addr = base - 32'(4 + $urandom % 64);
         else if (r == 1) addr = base + MEM_BYTES + 32'($urandom % 64);
         else addr = base + 32'(($urandom % MW) * 4) + low;
         xfer(k, ($urandom % 10) != 0, 2'($urandom), addr, 1'($urandom), size, $urandom);
      end
      idle(k);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (hready[k] !== e_rdy[k][cyc % 16] || hresp[k] !== e_resp[k][cyc % 16] ||
                hrdata[k] !== e_data[k][cyc % 16]) begin
               errors++;
               $display("FAIL bus%0d cycle%0d actual ready=%0b resp=%0d data=%h required ready=%0b resp=%0d data=%h",
                        k, cyc, hready[k], hresp[k], hrdata[k],
                        e_rdy[k][cyc % 16], e_resp[k][cyc % 16], e_data[k][cyc % 16]);
            end
            e_rdy[k][cyc % 16]  = 1'b1;
            e_resp[k][cyc % 16] = 2'b00;
            e_data[k][cyc % 16] = 32'h0;
         end
         cyc++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual still running required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst[k]    = 1'b1;
         hsel[k]   = 1'b0;
         haddr[k]  = 32'h0;
         htrans[k] = 2'b00;
         hwrite[k] = 1'b0;
         hsize[k]  = 3'd0;
         hburst[k] = 3'd0;
         hwdata[k] = 32'h0;
         model_reset(k);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) rst[k] = 1'b0;
      @(negedge clk);
      fork
         run(0);
         run(1);
         run(2);
      join
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
